pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv | 75 +++++++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: controller state
// encoding, PC source codes, forwarding source codes and a saturating
// increment helper used by the performance counters.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] satInc(input logic [15:0] value, input logic enable);
        if (enable && (value != CNT_MAX)) begin
            return value + 16'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// Purely combinational operand forwarding selection and load-use
// detection for the instruction currently sitting in ID.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [2:0] i_idRs1,
    input  logic [2:0] i_idRs2,
    input  logic       i_idUseRs1,
    input  logic       i_idUseRs2,
    input  logic [2:0] i_exRd,
    input  logic [2:0] i_memRd,
    input  logic [2:0] i_wbRd,
    input  logic       i_exRegWr,
    input  logic       i_memRegWr,
    input  logic       i_wbRegWr,
    input  logic       i_exMemRd,
    output logic [1:0] o_fwdA,
    output logic [1:0] o_fwdB,
    output logic       o_loadUse
);

    // R0 is hardwired zero, so a stage writing R0 is never a producer.
    // A load in EX has no data yet, so it is excluded as an EX source.
    logic w_exProducer;
    logic w_memProducer;
    logic w_wbProducer;
    logic w_exLoadProducer;

    fwd_sel_e w_fwdA;
    fwd_sel_e w_fwdB;

    assign w_exProducer     = i_exRegWr  & ~i_exMemRd & (i_exRd  != 3'd0);
    assign w_memProducer    = i_memRegWr & (i_memRd != 3'd0);
    assign w_wbProducer     = i_wbRegWr  & (i_wbRd  != 3'd0);
    assign w_exLoadProducer = i_exRegWr  &  i_exMemRd & (i_exRd  != 3'd0);

    // Operand A source: youngest matching producer wins (EX, then MEM, then WB).
    always_comb begin
        w_fwdA = FWD_RF;
        if (i_idUseRs1) begin
            if (w_exProducer && (i_exRd == i_idRs1)) begin
                w_fwdA = FWD_EX;
            end else if (w_memProducer && (i_memRd == i_idRs1)) begin
                w_fwdA = FWD_MEM;
            end else if (w_wbProducer && (i_wbRd == i_idRs1)) begin
                w_fwdA = FWD_WB;
            end
        end
    end

    // Operand B source: same priority as operand A, keyed on rs2.
    always_comb begin
        w_fwdB = FWD_RF;
        if (i_idUseRs2) begin
            if (w_exProducer && (i_exRd == i_idRs2)) begin
                w_fwdB = FWD_EX;
            end else if (w_memProducer && (i_memRd == i_idRs2)) begin
                w_fwdB = FWD_MEM;
            end else if (w_wbProducer && (i_wbRd == i_idRs2)) begin
                w_fwdB = FWD_WB;
            end
        end
    end

    // A load in EX feeding a source that ID actually reads needs one bubble.
    always_comb begin
        o_loadUse = w_exLoadProducer &
                    ((i_idUseRs1 & (i_exRd == i_idRs1)) |
                     (i_idUseRs2 & (i_exRd == i_idRs2)));
    end

    assign o_fwdA = w_fwdA;
    assign o_fwdB = w_fwdB;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait/timeout FSM, flush/stall/jump
// priority resolution, operand forwarding and saturating stall/flush
// performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd200
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_jump,
    input  logic [2:0]  ex_rd,
    input  logic [2:0]  mem_rd,
    input  logic [2:0]  wb_rd,
    input  logic        ex_regwr,
    input  logic        mem_regwr,
    input  logic        wb_regwr,
    input  logic        ex_memrd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        kill_if,
    output logic        kill_id,
    output logic        freeze_all,
    output logic [1:0]  pc_src,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    ctrl_state_e r_state;
    logic [7:0]  r_waitCnt;
    logic        r_memErr;
    logic [15:0] r_stallCnt;
    logic [15:0] r_flushCnt;

    logic        w_loadUse;
    logic        w_freeze;
    logic        w_pcHold;
    logic        w_ifidHold;
    logic        w_bubble;
    logic        w_killIf;
    logic        w_killId;
    pc_src_e     w_pcSrc;

    hazard_fwd_unit u_hazardFwd (
        .i_idRs1    (id_rs1),
        .i_idRs2    (id_rs2),
        .i_idUseRs1 (id_use_rs1),
        .i_idUseRs2 (id_use_rs2),
        .i_exRd     (ex_rd),
        .i_memRd    (mem_rd),
        .i_wbRd     (wb_rd),
        .i_exRegWr  (ex_regwr),
        .i_memRegWr (mem_regwr),
        .i_wbRegWr  (wb_regwr),
        .i_exMemRd  (ex_memrd),
        .o_fwdA     (fwd_a),
        .o_fwdB     (fwd_b),
        .o_loadUse  (w_loadUse)
    );

    // Freeze starts in the very cycle a request misses, so RUN looks at the inputs too.
    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            RUN:     w_freeze = mem_req & ~mem_ready;
            MWAIT:   w_freeze = ~mem_ready;
            HALT:    w_freeze = 1'b1;
            default: w_freeze = 1'b0;
        endcase
    end

    // Resolve competing hazards: freeze beats branch beats load-use beats jump.
    always_comb begin
        w_pcHold   = 1'b0;
        w_ifidHold = 1'b0;
        w_bubble   = 1'b0;
        w_killIf   = 1'b0;
        w_killId   = 1'b0;
        w_pcSrc    = PC_SEQ;
        if (w_freeze) begin
            w_pcHold   = 1'b1;
            w_ifidHold = 1'b1;
        end else if (ex_branch_taken) begin
            w_pcSrc  = PC_BRANCH;
            w_killIf = 1'b1;
            w_killId = 1'b1;
        end else if (w_loadUse) begin
            w_pcHold   = 1'b1;
            w_ifidHold = 1'b1;
            w_bubble   = 1'b1;
        end else if (id_jump) begin
            w_pcSrc  = PC_JUMP;
            w_killIf = 1'b1;
        end
    end

    // Memory access FSM: wait out slow accesses, give up into HALT after the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_waitCnt <= 8'd0;
            r_memErr  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        r_state   <= MWAIT;
                        r_waitCnt <= 8'd0;
                    end
                end
                MWAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else if ((r_waitCnt + 8'd1) == MEM_TIMEOUT) begin
                        r_state  <= HALT;
                        r_memErr <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Performance counters: cycles spent holding the PC and cycles killing IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= 16'd0;
            r_flushCnt <= 16'd0;
        end else begin
            r_stallCnt <= satInc(r_stallCnt, w_pcHold);
            r_flushCnt <= satInc(r_flushCnt, w_killIf);
        end
    end

    assign freeze_all  = w_freeze;
    assign pc_hold     = w_pcHold;
    assign ifid_hold   = w_ifidHold;
    assign idex_bubble = w_bubble;
    assign kill_if     = w_killIf;
    assign kill_id     = w_killId;
    assign pc_src      = w_pcSrc;
    assign mem_err     = r_memErr;
    assign stall_cnt   = r_stallCnt;
    assign flush_cnt   = r_flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] TB_TIMEOUT = 8'd4;
    localparam int SAT_CYCLES = 70000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, id_jump;
    logic [2:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_regwr, mem_regwr, wb_regwr;
    logic        ex_memrd, ex_branch_taken, mem_req, mem_ready;
    logic        pc_hold, ifid_hold, idex_bubble, kill_if, kill_id, freeze_all;
    logic [1:0]  pc_src, fwd_a, fwd_b;
    logic        mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model: 0 = running, 1 = waiting on memory, 2 = halted
    int mMode;
    int mWaitCycles;
    bit mErr;
    int mStall;
    int mFlush;
    bit mExpHold;
    bit mExpKill;
    bit mObsFreeze;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_jump(id_jump),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
        .ex_memrd(ex_memrd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .kill_if(kill_if), .kill_id(kill_id), .freeze_all(freeze_all),
        .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Forwarding source from the rules: first producing stage (EX, MEM, WB) writing the register.
    function automatic int modelFwd(input logic [2:0] src, input logic useSrc);
        logic [2:0] rdList [3];
        bit         wrList [3];
        rdList[0] = ex_rd;  wrList[0] = ex_regwr && !ex_memrd;
        rdList[1] = mem_rd; wrList[1] = mem_regwr;
        rdList[2] = wb_rd;  wrList[2] = wb_regwr;
        if (!useSrc) return 0;
        for (int s = 0; s < 3; s++) begin
            if (wrList[s] && rdList[s] != 3'd0 && rdList[s] == src) return s + 1;
        end
        return 0;
    endfunction

    task automatic setIdle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_jump = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwr = 0; mem_regwr = 0; wb_regwr = 0;
        ex_memrd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 1;
    endtask

    // Compare every combinational output against the model for the current inputs.
    task automatic checkCombo();
        bit freeze, luse;
        int expSrc;
        bit eHold, eBub, eKif, eKid;
        freeze = (mMode == 2) || (mMode == 1 && !mem_ready) || (mMode == 0 && mem_req && !mem_ready);
        luse = ex_memrd && ex_regwr && ex_rd != 0 &&
               ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        expSrc = 0; eHold = 0; eBub = 0; eKif = 0; eKid = 0;
        if (freeze) begin
            eHold = 1;
        end else if (ex_branch_taken) begin
            expSrc = 2; eKif = 1; eKid = 1;
        end else if (luse) begin
            eHold = 1; eBub = 1;
        end else if (id_jump) begin
            expSrc = 1; eKif = 1;
        end
        mExpHold = eHold;
        mExpKill = eKif;
        mObsFreeze = freeze_all;
        checkOutput("freeze_all", freeze_all, freeze);
        checkOutput("pc_hold", pc_hold, eHold);
        checkOutput("ifid_hold", ifid_hold, eHold);
        checkOutput("idex_bubble", idex_bubble, eBub);
        checkOutput("kill_if", kill_if, eKif);
        checkOutput("kill_id", kill_id, eKid);
        checkOutput("pc_src", pc_src, expSrc);
        checkOutput("fwd_a", fwd_a, modelFwd(id_rs1, id_use_rs1));
        checkOutput("fwd_b", fwd_b, modelFwd(id_rs2, id_use_rs2));
    endtask

    // One clock cycle: check combinational view, clock it, advance model, check registers.
    task automatic applyStimulus();
        @(negedge clk);
        checkCombo();
        @(posedge clk);
        if (mMode == 0) begin
            if (mem_req && !mem_ready) begin
                mMode = 1;
                mWaitCycles = 0;
            end
        end else if (mMode == 1) begin
            if (mem_ready) begin
                mMode = 0;
            end else begin
                mWaitCycles++;
                if (mWaitCycles >= int'(TB_TIMEOUT)) begin
                    mMode = 2;
                    mErr = 1;
                end
            end
        end
        if (mExpHold) mStall = (mStall >= 65535) ? 65535 : mStall + 1;
        if (mExpKill) mFlush = (mFlush >= 65535) ? 65535 : mFlush + 1;
        #1;
        checkOutput("stall_cnt", stall_cnt, mStall);
        checkOutput("flush_cnt", flush_cnt, mFlush);
        checkOutput("mem_err", mem_err, mErr);
    endtask

    // Asynchronous reset pulse held across one rising edge, released just after it.
    task automatic applyReset();
        rst_n = 1'b0;
        mMode = 0; mWaitCycles = 0; mErr = 0; mStall = 0; mFlush = 0;
        #1;
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_flush_cnt", flush_cnt, 0);
        checkOutput("rst_mem_err", mem_err, 0);
        checkCombo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int flushBefore, stallBefore, freezeCycles;
        rst_n = 1'b0;
        setIdle();
        #3;
        applyReset();

        // Forward from EX for an ALU producer.
        setIdle();
        ex_rd = 3; ex_regwr = 1; id_rs1 = 3; id_use_rs1 = 1;
        stallBefore = mStall;
        applyStimulus();
        checkOutput("alu_fwd_a_ex", fwd_a, 1);
        checkOutput("alu_no_stall", stall_cnt, stallBefore);

        // Same producer but it is a load: stall with a bubble instead.
        ex_memrd = 1;
        stallBefore = mStall;
        applyStimulus();
        checkOutput("lu_pc_hold", pc_hold, 1);
        checkOutput("lu_bubble", idex_bubble, 1);
        checkOutput("lu_not_ex", fwd_a == 2'b01, 0);
        checkOutput("lu_stall_inc", stall_cnt, stallBefore + 1);

        // Every stage writes R5: EX wins; then R0 everywhere never forwards.
        setIdle();
        ex_rd = 5; mem_rd = 5; wb_rd = 5;
        ex_regwr = 1; mem_regwr = 1; wb_regwr = 1;
        id_rs2 = 5; id_use_rs2 = 1;
        applyStimulus();
        checkOutput("all5_fwd_b", fwd_b, 1);
        ex_rd = 0; mem_rd = 0; wb_rd = 0; id_rs2 = 0;
        applyStimulus();
        checkOutput("r0_fwd_b", fwd_b, 0);

        // Branch beats load-use and jump.
        setIdle();
        ex_rd = 2; ex_regwr = 1; ex_memrd = 1; id_rs1 = 2; id_use_rs1 = 1;
        id_jump = 1; ex_branch_taken = 1;
        flushBefore = mFlush;
        applyStimulus();
        checkOutput("br_pc_src", pc_src, 2);
        checkOutput("br_kill_id", kill_id, 1);
        checkOutput("br_no_bubble", idex_bubble, 0);
        checkOutput("br_flush_inc", flush_cnt, flushBefore + 1);

        // Load-use beats jump.
        ex_branch_taken = 0;
        applyStimulus();
        checkOutput("lu_jmp_pc_src", pc_src, 0);

        // Three-cycle memory wait then completion.
        setIdle();
        mem_req = 1; mem_ready = 0;
        freezeCycles = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            freezeCycles += int'(mObsFreeze);
        end
        mem_ready = 1;
        applyStimulus();
        freezeCycles += int'(mObsFreeze);
        mem_req = 0;
        applyStimulus();
        freezeCycles += int'(mObsFreeze);
        checkOutput("mwait_freeze_cycles", freezeCycles, 3);
        checkOutput("mwait_no_err", mem_err, 0);

        // Memory never answers: halt after the timeout, stay there until reset.
        setIdle();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 1 + int'(TB_TIMEOUT); i++) applyStimulus();
        checkOutput("halt_mem_err", mem_err, 1);
        mem_ready = 1; mem_req = 0; ex_branch_taken = 1; id_jump = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("halt_freeze", freeze_all, 1);
        checkOutput("halt_no_kill", kill_if, 0);
        applyReset();
        setIdle();
        applyStimulus();
        checkOutput("post_rst_no_freeze", freeze_all, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            id_rs1 = 3'($urandom_range(0, 7)); id_rs2 = 3'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            id_jump = ($urandom_range(0, 5) == 0);
            ex_rd = 3'($urandom_range(0, 3)); mem_rd = 3'($urandom_range(0, 3)); wb_rd = 3'($urandom_range(0, 3));
            id_rs1 = (id_rs1 > 3) ? id_rs1 - 3'd4 : id_rs1;
            ex_regwr = 1'($urandom); mem_regwr = 1'($urandom); wb_regwr = 1'($urandom);
            ex_memrd = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_req = ($urandom_range(0, 7) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) applyReset();
            else applyStimulus();
        end

        // Long load-use stall: stall counter saturates and does not wrap.
        applyReset();
        setIdle();
        ex_rd = 3; ex_regwr = 1; ex_memrd = 1; id_rs1 = 3; id_use_rs1 = 1;
        for (int i = 0; i < SAT_CYCLES; i++) begin
            @(posedge clk);
            #1;
            if (i == 65533 || i == SAT_CYCLES - 1) begin
                checkOutput("sat_stall_cnt", stall_cnt, (i + 1 > 65535) ? 65535 : i + 1);
            end
        end
        checkOutput("sat_flush_cnt", flush_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
